// File: rtl/dpram_port_arbiter.sv
// Round-robin arbiter letting two requesters share one synchronous-RAM port.
// The RAM's own address register is the pipeline stage; acks return one cycle after issue.
module dpram_port_arbiter #(
  parameter int DW = 32,
  parameter int AW = 11
) (
  input  logic          inclock,
  input  logic          inaclr_a,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_data,
  output logic          ram_we,
  output logic          ram_clken,
  output logic          ram_aclr,
  input  logic [DW-1:0] ram_q
);

  logic [1:0]    req;
  logic [1:0]    we;
  logic [AW-1:0] addr  [2];
  logic [DW-1:0] wdata [2];
  logic [1:0]    elig;
  logic [1:0]    ack;
  logic [DW-1:0] rdata [2];

  logic resp_valid_q, resp_valid_d;
  logic resp_id_q,    resp_id_d;
  logic resp_we_q,    resp_we_d;
  logic last_grant_q, last_grant_d;

  logic grant_valid;
  logic grant_id;

  assign req      = {req1, req0};
  assign we       = {we1, we0};
  assign addr[0]  = addr0;
  assign addr[1]  = addr1;
  assign wdata[0] = wdata0;
  assign wdata[1] = wdata1;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_req
      // A requester whose response is in flight still holds req; keep it out of arbitration.
      assign elig[gi]  = req[gi] & ~(resp_valid_q & (resp_id_q == 1'(gi)));
      assign ack[gi]   = resp_valid_q & (resp_id_q == 1'(gi));
      assign rdata[gi] = (ack[gi] && !resp_we_q) ? ram_q : '0;
    end
  endgenerate

  assign ack0     = ack[0];
  assign ack1     = ack[1];
  assign rdata0   = rdata[0];
  assign rdata1   = rdata[1];
  assign ram_aclr = inaclr_a;

  always_comb begin
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    if (elig[0] && elig[1]) begin
      grant_valid = 1'b1;
      grant_id    = ~last_grant_q;
    end else if (elig[0]) begin
      grant_valid = 1'b1;
      grant_id    = 1'b0;
    end else if (elig[1]) begin
      grant_valid = 1'b1;
      grant_id    = 1'b1;
    end
  end

  // RAM port is forced quiet during reset even though the grant logic may still see requests.
  always_comb begin
    ram_clken = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_data  = '0;
    if (grant_valid && !inaclr_a) begin
      ram_clken = 1'b1;
      ram_we    = we[grant_id];
      ram_addr  = addr[grant_id];
      ram_data  = wdata[grant_id];
    end
  end

  always_comb begin
    resp_valid_d = grant_valid;
    resp_id_d    = grant_id;
    resp_we_d    = grant_valid & we[grant_id];
    last_grant_d = grant_valid ? grant_id : last_grant_q;
  end

  always_ff @(posedge inclock or posedge inaclr_a) begin
    if (inaclr_a) begin
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_we_q    <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_we_q    <= resp_we_d;
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Scoreboard bench for dpram_port_arbiter: per-cycle expectations are queued as stimulus
// is driven and compared against the DUT at the falling edge of that cycle.
module tb_dpram_port_arbiter;
  localparam int DW = 32;
  localparam int AW = 11;

  localparam logic [DW-1:0] M05  = 32'hDEADBEEF;
  localparam logic [DW-1:0] M10  = 32'h1010A5A5;
  localparam logic [DW-1:0] M20  = 32'h2020C3C3;
  localparam logic [DW-1:0] WVAL = 32'h12345678;

  logic          inclock = 1'b0;
  logic          inaclr_a;
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, ack1;
  logic [DW-1:0] rdata0, rdata1;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data;
  logic          ram_we, ram_clken, ram_aclr;
  logic [DW-1:0] ram_q;

  always #5 inclock = ~inclock;

  dpram_port_arbiter #(.DW(DW), .AW(AW)) dut (
    .inclock(inclock), .inaclr_a(inaclr_a),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we), .ram_clken(ram_clken),
    .ram_aclr(ram_aclr), .ram_q(ram_q)
  );

  // Behavioural RAM with registered address; backdoor port used only for preloading.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [AW-1:0] addr_reg;
  logic          bk_we;
  logic [AW-1:0] bk_addr;
  logic [DW-1:0] bk_data;

  always @(posedge inclock or posedge ram_aclr) begin
    if (ram_aclr) begin
      addr_reg <= '0;
      if (bk_we) mem[bk_addr] <= bk_data;
    end else if (ram_clken) begin
      addr_reg <= ram_addr;
      if (ram_we) mem[ram_addr] <= ram_data;
    end
  end
  assign ram_q = mem[addr_reg];

  typedef struct packed {
    logic          clken;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          a0;
    logic [DW-1:0] r0;
    logic          a1;
    logic [DW-1:0] r1;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic void push(input logic clken, input logic we, input logic [AW-1:0] addr,
                               input logic [DW-1:0] data, input logic a0, input logic [DW-1:0] r0,
                               input logic a1, input logic [DW-1:0] r1);
    exp_t e;
    e.clken = clken; e.we = we; e.addr = addr; e.data = data;
    e.a0 = a0; e.r0 = r0; e.a1 = a1; e.r1 = r1;
    exp_q.push_back(e);
  endfunction

  function automatic void push_idle();
    push(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
  endfunction

  // Compare this cycle's outputs against the oldest expectation, then advance one cycle.
  task automatic step();
    exp_t e;
    @(negedge inclock);
    if (exp_q.size() == 0) begin
      check_eq("queue_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check_eq("ram_clken", 32'(ram_clken), 32'(e.clken));
      check_eq("ram_we",    32'(ram_we),    32'(e.we));
      check_eq("ram_addr",  32'(ram_addr),  32'(e.addr));
      check_eq("ram_data",  ram_data,       e.data);
      check_eq("ack0",      32'(ack0),      32'(e.a0));
      check_eq("rdata0",    rdata0,         e.r0);
      check_eq("ack1",      32'(ack1),      32'(e.a1));
      check_eq("rdata1",    rdata1,         e.r1);
      check_eq("ram_aclr",  32'(ram_aclr),  32'(inaclr_a));
      $display("cyc %0d: clken=%b we=%b addr=%h ack0=%b rdata0=%h ack1=%b rdata1=%h",
               cyc, ram_clken, ram_we, ram_addr, ack0, rdata0, ack1, rdata1);
    end
    @(posedge inclock);
    #1;
    cyc++;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bk_we = 1'b1; bk_addr = a; bk_data = d;
    @(posedge inclock);
    #1;
    bk_we = 1'b0;
  endtask

  initial begin
    inaclr_a = 1'b1;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    bk_we = 1'b0; bk_addr = '0; bk_data = '0;
    #2;
    preload(11'h005, M05);
    preload(11'h010, M10);
    preload(11'h020, M20);

    // Reset state: a request during reset must not reach the RAM port.
    req0 = 1'b1; we0 = 1'b1; addr0 = 11'h005; wdata0 = 32'hFFFF_FFFF;
    push_idle(); step();
    req0 = 1'b0; we0 = 1'b0; wdata0 = '0;
    inaclr_a = 1'b0;

    // Single read by requester 0.
    req0 = 1'b1; addr0 = 11'h005;
    push(1'b1, 1'b0, 11'h005, '0, 1'b0, '0, 1'b0, '0); step();
    push(1'b0, 1'b0, '0, '0, 1'b1, M05, 1'b0, '0);     step();
    req0 = 1'b0;
    push_idle(); step();

    // Requester 1 alone held for 6 cycles: one access every 2 cycles.
    req1 = 1'b1; addr1 = 11'h020;
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) push(1'b1, 1'b0, 11'h020, '0, 1'b0, '0, 1'b0, '0);
      else            push(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1, M20);
      step();
    end
    req1 = 1'b0;

    // Both held: last grant was 1, so 0 wins first, then strict interleave.
    req0 = 1'b1; addr0 = 11'h010;
    req1 = 1'b1; addr1 = 11'h020;
    for (int k = 0; k < 6; k++) begin
      push(1'b1, 1'b0, (k % 2 == 0) ? 11'h010 : 11'h020, '0,
           (k % 2 == 1), (k % 2 == 1) ? M10 : '0,
           (k >= 2 && k % 2 == 0), (k >= 2 && k % 2 == 0) ? M20 : '0);
      step();
    end
    req0 = 1'b0; req1 = 1'b0;
    push(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1, M20); step();

    // Write to the top address by 0, read back by 1 the next cycle.
    req0 = 1'b1; we0 = 1'b1; addr0 = 11'h7FF; wdata0 = WVAL;
    push(1'b1, 1'b1, 11'h7FF, WVAL, 1'b0, '0, 1'b0, '0); step();
    req1 = 1'b1; we1 = 1'b0; addr1 = 11'h7FF;
    push(1'b1, 1'b0, 11'h7FF, '0, 1'b1, '0, 1'b0, '0);   step();
    req0 = 1'b0; we0 = 1'b0; wdata0 = '0;
    push(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1, WVAL);      step();
    req1 = 1'b0;
    push_idle(); step();

    // Reset during the response cycle: ack suppressed, request reissued afterwards.
    req0 = 1'b1; addr0 = 11'h005;
    push(1'b1, 1'b0, 11'h005, '0, 1'b0, '0, 1'b0, '0); step();
    inaclr_a = 1'b1;
    push_idle(); step();
    inaclr_a = 1'b0;
    push(1'b1, 1'b0, 11'h005, '0, 1'b0, '0, 1'b0, '0); step();
    push(1'b0, 1'b0, '0, '0, 1'b1, M05, 1'b0, '0);     step();
    req0 = 1'b0;

    // Idle for 4 cycles; last grant (0) must survive, so 1 wins the next tie.
    for (int k = 0; k < 4; k++) begin
      push_idle(); step();
    end
    req0 = 1'b1; addr0 = 11'h010;
    req1 = 1'b1; addr1 = 11'h020;
    push(1'b1, 1'b0, 11'h020, '0, 1'b0, '0, 1'b0, '0); step();
    push(1'b1, 1'b0, 11'h010, '0, 1'b0, '0, 1'b1, M20); step();
    req0 = 1'b0; req1 = 1'b0;
    push(1'b0, 1'b0, '0, '0, 1'b1, M10, 1'b0, '0);     step();
    push_idle(); step();

    check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout cyc=%0d got=running exp=finished", cyc);
    $fatal(1, "timeout");
  end
endmodule
